// File: rtl/vga_sync_core.sv
// vga_sync_core: VGA raster timing generator and terminal pixel sink.
// Publishes the current pixel coordinates and a pixel tick to upstream
// stream cores, and drives the physical hsync/vsync/rgb pins. Sync and
// blanking are delayed by DLY clocks to line up with the stream pipeline.
module vga_sync_core #(
   parameter int CD  = 4,    // system clocks per pixel
   parameter int DLY = 2,    // stream pipeline latency in clk cycles (>= 1)
   parameter int HD  = 640,
   parameter int HF  = 16,
   parameter int HR  = 96,
   parameter int HB  = 48,
   parameter int VD  = 480,
   parameter int VF  = 10,
   parameter int VR  = 2,
   parameter int VB  = 33
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        write,
   input  logic [13:0] addr,
   input  logic [31:0] wr_data,
   input  logic [11:0] si_rgb,
   output logic [10:0] hc,
   output logic [10:0] vc,
   output logic        p_tick,
   output logic        frame_start,
   output logic        hsync,
   output logic        vsync,
   output logic [11:0] rgb
);

   localparam int HT = HD + HF + HR + HB;
   localparam int VT = VD + VF + VR + VB;
   localparam int TW = (CD > 1) ? $clog2(CD) : 1;

   localparam logic [TW-1:0] TICK_LAST = TW'(CD - 1);
   localparam logic [10:0]   H_LAST    = 11'(HT - 1);
   localparam logic [10:0]   V_LAST    = 11'(VT - 1);
   localparam logic [10:0]   H_DISP    = 11'(HD);
   localparam logic [10:0]   V_DISP    = 11'(VD);
   localparam logic [10:0]   HS_FIRST  = 11'(HD + HF);
   localparam logic [10:0]   HS_LAST   = 11'(HD + HF + HR - 1);
   localparam logic [10:0]   VS_FIRST  = 11'(VD + VF);
   localparam logic [10:0]   VS_LAST   = 11'(VD + VF + VR - 1);

   logic [TW-1:0]  tick_q, tick_d;
   logic [10:0]    hc_q, hc_d;
   logic [10:0]    vc_q, vc_d;
   logic           frame_start_q, frame_start_d;
   logic [DLY-1:0] hs_dly_q, hs_dly_d;
   logic [DLY-1:0] vs_dly_q, vs_dly_d;
   logic [DLY-1:0] von_dly_q, von_dly_d;
   logic           hsync_q, hsync_d;
   logic           vsync_q, vsync_d;
   logic [11:0]    rgb_q, rgb_d;
   logic           en_q, en_d;

   logic tick_last;
   logic hs_raw, vs_raw, von_raw;

   // Only the enable bit of word 0 is meaningful; the rest of the slot bus is ignored.
   logic unused_slot_bits;
   assign unused_slot_bits = ^{addr[13:2], wr_data[31:1]};

   assign tick_last = (tick_q == TICK_LAST);

   // Undelayed sync and display-window flags for the current coordinates.
   assign hs_raw  = !((hc_q >= HS_FIRST) && (hc_q <= HS_LAST));
   assign vs_raw  = !((vc_q >= VS_FIRST) && (vc_q <= VS_LAST));
   assign von_raw = (hc_q < H_DISP) && (vc_q < V_DISP);

   // Next state of the pixel tick divider and the raster counters.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      tick_d        = tick_last ? '0 : tick_q + 1'b1;
      hc_d          = hc_q;
      vc_d          = vc_q;
      frame_start_d = 1'b0;
      if (tick_last) begin
         if (hc_q == H_LAST) begin
            hc_d = '0;
            if (vc_q == V_LAST) begin
               vc_d          = '0;
               frame_start_d = 1'b1;
            end else begin
               vc_d = vc_q + 11'd1;
            end
         end else begin
            hc_d = hc_q + 11'd1;
         end
      end
   end

   // Delay lines shift every clk; stage 0 captures the raw flags.
   always_comb begin
      hs_dly_d     = hs_dly_q;
      vs_dly_d     = vs_dly_q;
      von_dly_d    = von_dly_q;
      hs_dly_d[0]  = hs_raw;
      vs_dly_d[0]  = vs_raw;
      von_dly_d[0] = von_raw;
      for (int i = 1; i < DLY; i++) begin
         hs_dly_d[i]  = hs_dly_q[i-1];
         vs_dly_d[i]  = vs_dly_q[i-1];
         von_dly_d[i] = von_dly_q[i-1];
      end
   end

   // Pin drivers and the slot enable register.
   always_comb begin
      hsync_d = hs_dly_q[DLY-1];
      vsync_d = vs_dly_q[DLY-1];
      rgb_d   = (von_dly_q[DLY-1] && en_q) ? si_rgb : 12'h000;
      en_d    = en_q;
      if (cs && write && (addr[1:0] == 2'd0)) begin
         en_d = wr_data[0];
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         tick_q        <= '0;
         hc_q          <= '0;
         vc_q          <= '0;
         frame_start_q <= 1'b0;
         hs_dly_q      <= '1;
         vs_dly_q      <= '1;
         von_dly_q     <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         rgb_q         <= 12'h000;
         en_q          <= 1'b1;
      end else begin
         tick_q        <= tick_d;
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         frame_start_q <= frame_start_d;
         hs_dly_q      <= hs_dly_d;
         vs_dly_q      <= vs_dly_d;
         von_dly_q     <= von_dly_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         rgb_q         <= rgb_d;
         en_q          <= en_d;
      end
   end

   assign hc          = hc_q;
   assign vc          = vc_q;
   assign p_tick      = tick_last;
   assign frame_start = frame_start_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_sync_core.sv
// tb_vga_sync_core: self-checking bench for vga_sync_core.
// The raster is shrunk (HT = 56, VT = 19) so whole frames fit in a short run;
// CD and DLY keep their default values.
module tb_vga_sync_core;

   localparam int CD  = 4;
   localparam int DLY = 2;
   localparam int HD  = 40;
   localparam int HF  = 4;
   localparam int HR  = 6;
   localparam int HB  = 6;
   localparam int VD  = 12;
   localparam int VF  = 2;
   localparam int VR  = 2;
   localparam int VB  = 3;
   localparam int HT  = HD + HF + HR + HB;   // 56
   localparam int VT  = VD + VF + VR + VB;   // 19
   localparam int FRAME_CLKS = CD * HT * VT; // 4256

   logic        clk = 1'b0;
   logic        reset;
   logic        cs;
   logic        write;
   logic [13:0] addr;
   logic [31:0] wr_data;
   logic [11:0] si_rgb;
   logic [10:0] hc;
   logic [10:0] vc;
   logic        p_tick;
   logic        frame_start;
   logic        hsync;
   logic        vsync;
   logic [11:0] rgb;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   vga_sync_core #(
      .CD(CD), .DLY(DLY),
      .HD(HD), .HF(HF), .HR(HR), .HB(HB),
      .VD(VD), .VF(VF), .VR(VR), .VB(VB)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cs          (cs),
      .write       (write),
      .addr        (addr),
      .wr_data     (wr_data),
      .si_rgb      (si_rgb),
      .hc          (hc),
      .vc          (vc),
      .p_tick      (p_tick),
      .frame_start (frame_start),
      .hsync       (hsync),
      .vsync       (vsync),
      .rgb         (rgb)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Everything follows from n, the number of clk edges since reset was released:
   // pixel number = n / CD, position in frame = pixel mod (HT*VT).
   // Pins show the coordinates of n - (DLY+1) edges ago.
   bit          model_on = 1'b0;
   longint      n_m;
   bit          en_m;
   logic [10:0] e_hc, e_vc;
   logic        e_pt, e_fs, e_hs, e_vs;
   logic [11:0] e_rgb;

   function automatic void pix_at(input longint m, output int h, output int v);
      longint pos;
      pos = (m / CD) % (HT * VT);
      h   = int'(pos % HT);
      v   = int'(pos / HT);
   endfunction

   initial begin : model
      int h, v;
      forever begin
         @(posedge clk);
         if (reset) begin
            n_m      = 0;
            en_m     = 1'b1;
            e_hs     = 1'b1;
            e_vs     = 1'b1;
            e_rgb    = 12'h000;
            model_on = 1'b1;
         end else if (model_on) begin
            n_m++;
            if (n_m >= DLY + 1) begin
               pix_at(n_m - DLY - 1, h, v);
               e_hs  = !(h >= HD + HF && h < HD + HF + HR);
               e_vs  = !(v >= VD + VF && v < VD + VF + VR);
               e_rgb = (h < HD && v < VD && en_m) ? si_rgb : 12'h000;
            end else begin
               e_hs  = 1'b1;
               e_vs  = 1'b1;
               e_rgb = 12'h000;
            end
            if (cs && write && addr[1:0] == 2'd0) en_m = wr_data[0];
         end
         if (model_on) begin
            pix_at(n_m, h, v);
            e_hc = 11'(h);
            e_vc = 11'(v);
            e_pt = ((n_m % CD) == CD - 1);
            e_fs = (n_m > 0) && ((n_m % FRAME_CLKS) == 0);
         end
      end
   end

   // Compare every cycle, away from the active edge.
   initial begin : compare
      forever begin
         @(negedge clk);
         if (model_on) begin
            check("m_hc",          hc,          e_hc);
            check("m_vc",          vc,          e_vc);
            check("m_p_tick",      p_tick,      e_pt);
            check("m_frame_start", frame_start, e_fs);
            check("m_hsync",       hsync,       e_hs);
            check("m_vsync",       vsync,       e_vs);
            check("m_rgb",         rgb,         e_rgb);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic slot_write(input logic [13:0] a, input logic [31:0] d);
      cs      = 1'b1;
      write   = 1'b1;
      addr    = a;
      wr_data = d;
      @(negedge clk);
      cs      = 1'b0;
      write   = 1'b0;
   endtask

   // Returns at the first cycle of a fresh arrival at pixel (h, v).
   task automatic wait_hv(input int h, input int v, input string name);
      bit ok;
      bit was;
      ok  = 1'b0;
      was = (hc == 11'(h) && vc == 11'(v));
      for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
         @(negedge clk);
         if (hc == 11'(h) && vc == 11'(v)) begin
            if (!was) begin
               ok = 1'b1;
               break;
            end
         end else begin
            was = 1'b0;
         end
      end
      check(name, ok, 1);
   endtask

   // First 20 clks after reset release: p_tick on clks 3,7,11,15,19; hc = 5 after clk 20.
   task automatic check_first_20(input string tag);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         check({tag, "_p_tick"}, p_tick, (i == 3 || i == 7 || i == 11 || i == 15 || i == 19));
         if (i == DLY)     check({tag, "_rgb_before_first_pixel"}, rgb, 12'h000);
         if (i == DLY + 1) check({tag, "_first_pixel"}, rgb, si_rgb);
      end
      check({tag, "_hc_after_20"}, hc, 5);
      check({tag, "_vc_after_20"}, vc, 0);
      check({tag, "_hsync_after_20"}, hsync, 1);
      check({tag, "_vsync_after_20"}, vsync, 1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin : stim
      int  k;
      int  w;
      int  v0;
      bit  ok;

      reset   = 1'b1;
      cs      = 1'b0;
      write   = 1'b0;
      addr    = '0;
      wr_data = '0;
      si_rgb  = 12'hF0A;

      repeat (3) @(negedge clk);
      check("rst_hc", hc, 0);
      check("rst_vc", vc, 0);
      check("rst_p_tick", p_tick, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_hsync", hsync, 1);
      check("rst_vsync", vsync, 1);
      check("rst_rgb", rgb, 12'h000);
      reset = 1'b0;

      check_first_20("start");

      // hsync: falls DLY+1 clks after hc reaches 44, low for HR*CD = 24 clks.
      ok = 1'b0;
      for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
         @(negedge clk);
         if (hc == 11'(HD + HF)) begin ok = 1'b1; break; end
      end
      check("reach_hs_start", ok, 1);
      k = 0;
      do begin @(negedge clk); k++; end while (hsync !== 1'b0 && k < 100);
      check("hsync_fall_delay", k, 3);
      w = 0;
      while (hsync === 1'b0 && w < 10000) begin @(negedge clk); w++; end
      check("hsync_low_clks", w, 24);

      // vsync: falls DLY+1 clks after vc reaches 14, low for 2 lines = 448 clks.
      ok = 1'b0;
      for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
         @(negedge clk);
         if (vc == 11'(VD + VF)) begin ok = 1'b1; break; end
      end
      check("reach_vs_start", ok, 1);
      k = 0;
      do begin @(negedge clk); k++; end while (vsync !== 1'b0 && k < 100);
      check("vsync_fall_delay", k, 3);
      w = 0;
      while (vsync === 1'b0 && w < 10000) begin @(negedge clk); w++; end
      check("vsync_low_clks", w, 448);

      // frame_start: one clk wide at (0,0), period 4256 clks.
      ok = 1'b0;
      for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
         @(negedge clk);
         if (frame_start === 1'b1) begin ok = 1'b1; break; end
      end
      check("frame_start_seen", ok, 1);
      check("frame_start_hc", hc, 0);
      check("frame_start_vc", vc, 0);
      k = 0;
      do begin @(negedge clk); k++; end while (frame_start !== 1'b1 && k < 2 * FRAME_CLKS);
      check("frame_start_period", k, 4256);

      // Line wrap: hc = 55 on p_tick -> next clk hc = 0, vc = 1.
      ok = 1'b0;
      for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
         @(negedge clk);
         if (hc == 11'(HT - 1) && p_tick === 1'b1 && vc != 11'(VT - 1)) begin ok = 1'b1; break; end
      end
      check("reach_line_end", ok, 1);
      v0 = int'(vc);
      check("line_end_vc", v0, 0);
      @(negedge clk);
      check("wrap_hc", hc, 0);
      check("wrap_vc", vc, 1);

      // Video enable through the slot register.
      wait_hv(10, 5, "reach_px_a");
      slot_write(14'd0, 32'd0);
      wait_hv(10, 5, "reach_px_b");
      repeat (DLY + 1) @(negedge clk);
      check("rgb_disabled", rgb, 12'h000);
      slot_write(14'd0, 32'd1);
      wait_hv(10, 5, "reach_px_c");
      repeat (DLY + 1) @(negedge clk);
      check("rgb_reenabled", rgb, 12'hF0A);
      slot_write(14'd1, 32'd0);
      wait_hv(10, 5, "reach_px_d");
      repeat (DLY + 1) @(negedge clk);
      check("rgb_addr1_ignored", rgb, 12'hF0A);
      si_rgb = 12'h5A3;
      wait_hv(10, 5, "reach_px_e");
      repeat (DLY + 1) @(negedge clk);
      check("rgb_new_pixel", rgb, 12'h5A3);

      // Mid-frame reset during vsync with video disabled.
      slot_write(14'd0, 32'd0);
      wait_hv(30, VD + VF, "reach_reset_point");
      check("vsync_low_before_reset", vsync, 0);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_hc", hc, 0);
      check("mid_rst_vc", vc, 0);
      check("mid_rst_hsync", hsync, 1);
      check("mid_rst_vsync", vsync, 1);
      check("mid_rst_rgb", rgb, 12'h000);
      reset = 1'b0;
      check_first_20("restart");
      k = 20;
      while (frame_start !== 1'b1 && k < 2 * FRAME_CLKS) begin @(negedge clk); k++; end
      check("restart_first_frame_start", k, 4256);

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin : watchdog
      #(40 * FRAME_CLKS * 10);
      $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1, "watchdog expired");
   end

endmodule
